// File: rtl/fifosc_pkg.sv
// Shared definitions for the single-clock FIFO write arbiter: FSM encoding,
// default word width and the pointer-width helper.
package fifosc_pkg;

  localparam int FIFOSC_DATA_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } fifosc_state_e;

  // Width needed to index n items; never returns 0 so n=1 still gets a usable bit.
  function automatic int fifosc_ptr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifosc_rr_pick.sv
// Combinational round-robin picker: first set request scanning from rr_ptr
// upward with wrap, returned as one-hot vector plus binary index.
module fifosc_rr_pick
  import fifosc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = fifosc_ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [PTR_W-1:0]   win_idx,
  output logic               found
);

  int j;

  // NOTE: every output gets a default before the loop so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        win_idx   = PTR_W'(j);
        win_oh[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifosc_wr_arb.sv
// Round-robin write arbiter feeding one single-clock FIFO through a one-word
// output register, with flush sequencing. Define FIFOSC_WR_ARB_PRIO_EN to give
// requester 0 strict priority over the round-robin group.
module fifosc_wr_arb
  import fifosc_pkg::*;
#(
  parameter int DATA_WIDTH = FIFOSC_DATA_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int FLUSH_CYC  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          flush_req,
  input  logic                          fifo_full,
  output logic                          fifo_ins,
  output logic [DATA_WIDTH-1:0]         fifo_di,
  output logic                          fifo_flush,
  output logic                          busy
);

  localparam int PTR_W = fifosc_ptr_w(NUM_REQ);
  localparam int CNT_W = fifosc_ptr_w(FLUSH_CYC);

  fifosc_state_e      state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] rr_req, rr_oh, win_oh;
  logic [PTR_W-1:0]   rr_idx, win_idx, ptr_next;
  logic               rr_found, prio_hit, req_any;
  logic               out_vld, capture;

`ifdef FIFOSC_WR_ARB_PRIO_EN
  // Requester 0 sits outside the rotation; the others share the pointer.
  assign rr_req   = {req[NUM_REQ-1:1], 1'b0};
  assign prio_hit = req[0];
`else
  assign rr_req   = req;
  assign prio_hit = 1'b0;
`endif

  fifosc_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req     (rr_req),
    .rr_ptr  (rr_ptr_q),
    .win_oh  (rr_oh),
    .win_idx (rr_idx),
    .found   (rr_found)
  );

  assign win_oh   = prio_hit ? NUM_REQ'(1) : rr_oh;
  assign win_idx  = prio_hit ? '0 : rr_idx;
  assign req_any  = prio_hit | rr_found;
  assign ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

  assign out_vld    = (state_q == ST_HOLD);
  assign fifo_flush = (state_q == ST_FLUSH);
  assign busy       = out_vld | fifo_flush;
  assign fifo_ins   = out_vld & ~fifo_full;

  // A new word may enter only when the register is empty or draining this edge;
  // rst gates the grant so it clears together with the registered outputs.
  assign capture = ~rst & ~fifo_flush & ~flush_req & (~out_vld | fifo_ins) & req_any;
  assign gnt     = capture ? win_oh : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_req) begin
      state_d = ST_FLUSH;
      cnt_d   = CNT_W'(FLUSH_CYC - 1);
    end else begin
      unique case (state_q)
        ST_IDLE:  if (capture) state_d = ST_HOLD;
        ST_HOLD:  if (fifo_ins && !capture) state_d = ST_IDLE;
        ST_FLUSH: begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      fifo_di  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        fifo_di <= req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
        if (!prio_hit) rr_ptr_q <= ptr_next;
      end
    end
  end

endmodule
